// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-to-memory stage bundle plus the writeback/forwarding
// signals returned by the memory stage.
`default_nettype none

interface mem_stage_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] result;
  logic             do_exe_reg_write;
  logic [3:0]       exe_reg_addr;
  logic             is_load;
  logic             is_store;
  logic [WIDTH-1:0] store_data;
  logic             do_branch;
  logic             do_halt;
  logic [WIDTH-1:0] mem_value;
  logic             mem_reg_write;
  logic [3:0]       mem_reg_addr;
  logic             flushing;
  logic             halted;

  modport master (
    output result, do_exe_reg_write, exe_reg_addr, is_load, is_store,
           store_data, do_branch, do_halt,
    input  mem_value, mem_reg_write, mem_reg_addr, flushing, halted
  );

  modport slave (
    input  result, do_exe_reg_write, exe_reg_addr, is_load, is_store,
           store_data, do_branch, do_halt,
    output mem_value, mem_reg_write, mem_reg_addr, flushing, halted
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: data-memory access and register writeback, with branch squash
// window and sticky halt tracking.
`default_nettype none

module mem_stage #(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int         DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

  // Data memory is power-on zero and deliberately outside the reset domain.
  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic [WIDTH-1:0] mem_value_q, mem_value_d;
  logic             reg_write_q, reg_write_d;
  logic [3:0]       reg_addr_q,  reg_addr_d;
  logic [2:0]       fcnt_q,      fcnt_d;
  logic             halted_q,    halted_d;
  logic             rel_q,       rel_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  flushing;
  logic                  valid;
  logic                  mem_we;
  logic                  do_load;

  assign addr     = bus.result[ADDR_WIDTH-1:0];
  assign flushing = (fcnt_q != 3'd0);
  assign valid    = !flushing && !halted_q;
  assign do_load  = bus.is_load && !bus.is_store;
  assign mem_we   = rst && valid && bus.is_store;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_value_q <= '0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= 4'd0;
      fcnt_q      <= 3'd0;
      halted_q    <= 1'b1;
      rel_q       <= 1'b1;
    end else begin
      mem_value_q <= mem_value_d;
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      fcnt_q      <= fcnt_d;
      halted_q    <= halted_d;
      rel_q       <= rel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr] <= bus.store_data;
    end
  end

  // Next-state logic
  always_comb begin
    mem_value_d = do_load ? mem_q[addr] : bus.result;
    reg_addr_d  = bus.exe_reg_addr;
    reg_write_d = valid && !bus.is_store && bus.do_exe_reg_write;
    fcnt_d      = fcnt_q;
    if (valid && bus.do_branch) begin
      fcnt_d = FLUSH_INIT;
    end else if (flushing) begin
      fcnt_d = fcnt_q - 3'd1;
    end
    // The reset-time halt is only held past the first edge by a real do_halt.
    rel_d    = 1'b0;
    halted_d = (bus.do_halt && !flushing) || (halted_q && !rel_q);
  end

  // Outputs
  always_comb begin
    bus.mem_value     = mem_value_q;
    bus.mem_reg_write = reg_write_q;
    bus.mem_reg_addr  = reg_addr_q;
    bus.flushing      = flushing;
    bus.halted        = halted_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage writeback, memory, squash and halt.
`default_nettype none

module tb_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_stage_if #(.WIDTH(16)) bus ();

  mem_stage #(.WIDTH(16), .ADDR_WIDTH(8), .FLUSH_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.result           = '0;
    bus.do_exe_reg_write = 1'b0;
    bus.exe_reg_addr     = 4'd0;
    bus.is_load          = 1'b0;
    bus.is_store         = 1'b0;
    bus.store_data       = '0;
    bus.do_branch        = 1'b0;
    bus.do_halt          = 1'b0;
  endtask

  task automatic alu(input logic [15:0] res, input logic [3:0] rd, input logic we);
    idle();
    bus.result = res; bus.exe_reg_addr = rd; bus.do_exe_reg_write = we;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    idle();
    bus.is_store = 1'b1; bus.result = a; bus.store_data = d;
  endtask

  task automatic load(input logic [15:0] a, input logic [3:0] rd);
    idle();
    bus.is_load = 1'b1; bus.result = a; bus.exe_reg_addr = rd; bus.do_exe_reg_write = 1'b1;
  endtask

  initial begin
    idle();
    #1 rst = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("rst_value", 32'(bus.mem_value), 32'h0);
    check("rst_we", 32'(bus.mem_reg_write), 32'h0);
    check("rst_addr", 32'(bus.mem_reg_addr), 32'h0);
    check("rst_flush", 32'(bus.flushing), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h1);
    @(negedge clk) rst = 1'b1;
    step();
    check("release_halted", 32'(bus.halted), 32'h0);

    alu(16'h1234, 4'd3, 1'b1); step();
    check("alu_value", 32'(bus.mem_value), 32'h1234);
    check("alu_we", 32'(bus.mem_reg_write), 32'h1);
    check("alu_addr", 32'(bus.mem_reg_addr), 32'h3);

    store(16'h0010, 16'hBEEF); bus.do_exe_reg_write = 1'b1; step();
    check("store_we", 32'(bus.mem_reg_write), 32'h0);
    load(16'h0110, 4'd5); step();
    check("ld_wrap_value", 32'(bus.mem_value), 32'hBEEF);
    check("ld_wrap_addr", 32'(bus.mem_reg_addr), 32'h5);
    check("ld_wrap_we", 32'(bus.mem_reg_write), 32'h1);

    store(16'h0020, 16'hCAFE); bus.is_load = 1'b1; bus.do_exe_reg_write = 1'b1;
    bus.exe_reg_addr = 4'd6; step();
    check("st_ld_we", 32'(bus.mem_reg_write), 32'h0);
    load(16'h0020, 4'd7); step();
    check("st_ld_mem", 32'(bus.mem_value), 32'hCAFE);
    load(16'h0030, 4'd7); step();
    check("ld_init_zero", 32'(bus.mem_value), 32'h0);

    // Branch with its own write, then r1 (with stray branch+halt), r2, r3.
    alu(16'h0008, 4'd8, 1'b1); bus.do_branch = 1'b1; step();
    check("br_own_we", 32'(bus.mem_reg_write), 32'h1);
    check("br_flush_c1", 32'(bus.flushing), 32'h1);
    alu(16'h0001, 4'd1, 1'b1); bus.do_branch = 1'b1; bus.do_halt = 1'b1; step();
    check("r1_we", 32'(bus.mem_reg_write), 32'h0);
    check("br_flush_c2", 32'(bus.flushing), 32'h1);
    alu(16'h0002, 4'd2, 1'b1); step();
    check("r2_we", 32'(bus.mem_reg_write), 32'h0);
    check("br_flush_end", 32'(bus.flushing), 32'h0);
    alu(16'h0003, 4'd3, 1'b1); step();
    check("r3_we", 32'(bus.mem_reg_write), 32'h1);
    check("r3_value", 32'(bus.mem_value), 32'h3);
    check("halt_in_window", 32'(bus.halted), 32'h0);

    alu(16'h0000, 4'd0, 1'b0); bus.do_branch = 1'b1; step();
    store(16'h0040, 16'h5555); step();
    idle(); step();
    load(16'h0040, 4'd4); step();
    check("sq_store_mem", 32'(bus.mem_value), 32'h0);

    alu(16'h0009, 4'd9, 1'b1); bus.do_halt = 1'b1; step();
    check("halt_set", 32'(bus.halted), 32'h1);
    check("halt_own_we", 32'(bus.mem_reg_write), 32'h1);
    store(16'h0050, 16'h7777); step();
    check("halt_sticky", 32'(bus.halted), 32'h1);
    load(16'h0050, 4'd2); step();
    check("halt_store_mem", 32'(bus.mem_value), 32'h0);
    check("halt_ld_we", 32'(bus.mem_reg_write), 32'h0);

    // Fresh run: reset asserted inside a flush window.
    idle();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
    check("rerun_halted", 32'(bus.halted), 32'h0);
    store(16'h0060, 16'h1111); step();
    alu(16'h0000, 4'd0, 1'b0); bus.do_branch = 1'b1; step();
    check("mid_flush_on", 32'(bus.flushing), 32'h1);
    idle();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_flush", 32'(bus.flushing), 32'h0);
    check("mid_rst_halted", 32'(bus.halted), 32'h1);
    check("mid_rst_value", 32'(bus.mem_value), 32'h0);
    @(negedge clk) rst = 1'b1;
    step();
    load(16'h0060, 4'd1); step();
    check("mid_rst_mem", 32'(bus.mem_value), 32'h1111);
    load(16'h0010, 4'd1); step();
    check("mid_rst_mem_old", 32'(bus.mem_value), 32'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
